// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply and restoring divide unit
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               div_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               divzero_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 div_q;
  logic                 sign_q;
  logic                 sign_r_q;
  logic                 dz_q;
  // multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]     opnd_q;
  // multiply: {hi, lo} accumulator with multiplier in lo; divide: lo holds dividend/quotient
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     rem_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 sign1, sign2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic                 div_by_zero;
  logic                 accept;
  logic                 last_step;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem_next;
  logic [WIDTH-1:0]     div_quo_next;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [2*WIDTH-1:0]   mul_fix;
  logic [2*WIDTH-1:0]   fin_res;

  assign div_by_zero = div_i && (opdata2_i == '0);
  assign accept      = (state_q == S_IDLE) && start_i && !annul_i;
  assign last_step   = (state_q == S_RUN) && !annul_i && (cnt_q == LAST_CNT);
  assign result_o    = result_q;

  // Operand magnitudes: negative signed operands become their two's complement magnitude
  always_comb begin
    sign1 = signed_i & opdata1_i[WIDTH-1];
    sign2 = signed_i & opdata2_i[WIDTH-1];
    mag1  = sign1 ? -opdata1_i : opdata1_i;
    mag2  = sign2 ? -opdata2_i : opdata2_i;
  end

  // One iteration of shift-add multiply and restoring divide, plus sign fix-up of the final step
  always_comb begin
    mul_sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next     = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift    = {rem_q, prod_q[WIDTH-1]};
    div_diff     = div_shift - {1'b0, opnd_q};
    // shifted remainder is below twice the divisor, so the top bit of the trial is a clean sign
    div_ge       = ~div_diff[WIDTH];
    div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_next = {prod_q[WIDTH-2:0], div_ge};
    mul_fix      = sign_q ? -mul_next : mul_next;
    quo_fix      = sign_q ? -div_quo_next : div_quo_next;
    rem_fix      = sign_r_q ? -div_rem_next : div_rem_next;
    fin_res      = div_q ? {rem_fix, quo_fix} : mul_fix;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; annul always returns to IDLE and beats a start or the last RUN step
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = div_by_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy_o    = (state_q == S_RUN);
    ready_o   = (state_q == S_DONE);
    divzero_o = (state_q == S_DONE) && dz_q;
  end

  // Operand capture, iteration and result write on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= 1'b0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      div_q    <= div_i;
      sign_q   <= sign1 ^ sign2;
      sign_r_q <= sign1;
      dz_q     <= div_by_zero;
      opnd_q   <= div_i ? mag2 : mag1;
      prod_q   <= {{WIDTH{1'b0}}, (div_i ? mag1 : mag2)};
      rem_q    <= '0;
      if (div_by_zero) begin
        result_q <= '0;
      end
    end else if ((state_q == S_RUN) && !annul_i) begin
      cnt_q <= cnt_q + 1'b1;
      if (div_q) begin
        prod_q[WIDTH-1:0] <= div_quo_next;
        rem_q             <= div_rem_next;
      end else begin
        prod_q <= mul_next;
      end
      if (last_step) begin
        result_q <= fin_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit at WIDTH 32 and 8
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, annul_a, div_a, sgn_a;
  logic [31:0] op1_a, op2_a;
  logic [63:0] res_a;
  logic        rdy_a, busy_a, dz_a;

  logic        start_b, annul_b, div_b, sgn_b;
  logic [7:0]  op1_b, op2_b;
  logic [15:0] res_b;
  logic        rdy_b, busy_b, dz_b;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(start_a), .annul_i(annul_a), .div_i(div_a),
    .signed_i(sgn_a), .opdata1_i(op1_a), .opdata2_i(op2_a), .result_o(res_a),
    .ready_o(rdy_a), .busy_o(busy_a), .divzero_o(dz_a)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start_b), .annul_i(annul_b), .div_i(div_b),
    .signed_i(sgn_b), .opdata1_i(op1_b), .opdata2_i(op2_b), .result_o(res_b),
    .ready_o(rdy_b), .busy_o(busy_b), .divzero_o(dz_b)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_res32 = 64'd0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign-extended operands, truncated to result width
  function automatic logic [63:0] model(input int w, input bit dv, input bit sg,
                                        input logic [31:0] a, input logic [31:0] b,
                                        output bit dz);
    longint      sa, sb, q, r;
    logic [63:0] wm, m2, ua, ub;
    wm = (64'd1 << w) - 64'd1;
    m2 = (w >= 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
    ua = {32'd0, a} & wm;
    ub = {32'd0, b} & wm;
    sa = longint'(ua);
    sb = longint'(ub);
    if (sg && ua[w-1]) sa = sa - longint'(64'd1 << w);
    if (sg && ub[w-1]) sb = sb - longint'(64'd1 << w);
    dz = 1'b0;
    if (!dv) return 64'(sa * sb) & m2;
    if (ub == 64'd0) begin
      dz = 1'b1;
      return 64'd0;
    end
    q = sa / sb;
    r = sa % sb;
    return ((64'(r) & wm) << w) | (64'(q) & wm);
  endfunction

  task automatic drive(input int w, input bit st, input bit an, input bit dv, input bit sg,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      start_b = st; annul_b = an; div_b = dv; sgn_b = sg; op1_b = a[7:0]; op2_b = b[7:0];
    end else begin
      start_a = st; annul_a = an; div_a = dv; sgn_a = sg; op1_a = a; op2_a = b;
    end
  endtask

  task automatic get(input int w, output bit rdy, output bit bsy, output bit dz, output logic [63:0] res);
    if (w == 8) begin
      rdy = rdy_b; bsy = busy_b; dz = dz_b; res = {48'd0, res_b};
    end else begin
      rdy = rdy_a; bsy = busy_a; dz = dz_a; res = res_a;
    end
  endtask

  // One full operation; start is held high afterwards to show it is ignored in RUN and DONE
  task automatic run_op(input int w, input bit dv, input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp, res;
    bit          exp_dz, rdy, bsy, dz;
    int          lat, busy_n;
    exp = model(w, dv, sg, a, b, exp_dz);
    @(negedge clk);
    drive(w, 1'b1, 1'b0, dv, sg, a, b);
    lat = 0;
    busy_n = 0;
    rdy = 1'b0; bsy = 1'b0; dz = 1'b0; res = 64'd0;
    for (int n = 1; n <= w + 4; n++) begin
      @(negedge clk);
      drive(w, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      get(w, rdy, bsy, dz, res);
      if (bsy) busy_n++;
      if (rdy) begin
        lat = n;
        break;
      end
    end
    check_eq("latency", 64'(lat), 64'(exp_dz ? 1 : w + 1));
    check_eq("busy_cycles", 64'(busy_n), 64'(exp_dz ? 0 : w));
    check_eq("result", res, exp);
    check_eq("divzero", 64'(dz), 64'(exp_dz));
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    get(w, rdy, bsy, dz, res);
    check_eq("ready_single_pulse", 64'(rdy), 64'd0);
    check_eq("idle_after_done", 64'(bsy), 64'd0);
    if (w == 32) last_res32 = exp;
  endtask

  // Start a WIDTH=32 multiply and cancel it with annul or reset in RUN cycle kill_at
  task automatic kill_run(input bit use_rst, input int kill_at);
    bit          rdy, bsy, dz;
    logic [63:0] res;
    int          rdy_n;
    @(negedge clk);
    drive(32, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9abc_def1);
    rdy = 1'b0; bsy = 1'b0; dz = 1'b0; res = 64'd0;
    for (int n = 1; n <= kill_at; n++) begin
      @(negedge clk);
      drive(32, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    get(32, rdy, bsy, dz, res);
    check_eq("busy_before_kill", 64'(bsy), 64'd1);
    if (use_rst) rst = 1'b1;
    else annul_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    annul_a = 1'b0;
    get(32, rdy, bsy, dz, res);
    check_eq("kill_busy", 64'(bsy), 64'd0);
    check_eq("kill_ready", 64'(rdy), 64'd0);
    check_eq("kill_divzero", 64'(dz), 64'd0);
    check_eq("kill_result", res, use_rst ? 64'd0 : last_res32);
    rdy_n = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      get(32, rdy, bsy, dz, res);
      if (rdy) rdy_n++;
    end
    check_eq("no_ready_after_kill", 64'(rdy_n), 64'd0);
    if (use_rst) last_res32 = 64'd0;
  endtask

  task automatic random_ops(input int w, input int count);
    bit          dv, sg;
    logic [31:0] a, b;
    for (int i = 0; i < count; i++) begin
      dv = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin
          a = (w == 8) ? 32'h80 : 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(w, dv, sg, a, b);
    end
  endtask

  initial begin
    bit          rdy, bsy, dz;
    logic [63:0] res;
    rst = 1'b1;
    drive(32, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    get(32, rdy, bsy, dz, res);
    check_eq("reset_result", res, 64'd0);
    check_eq("reset_ready", 64'(rdy), 64'd0);
    check_eq("reset_busy", 64'(bsy), 64'd0);
    check_eq("reset_divzero", 64'(dz), 64'd0);
    get(8, rdy, bsy, dz, res);
    check_eq("reset_result8", res, 64'd0);
    rst = 1'b0;

    run_op(32, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(32, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    run_op(32, 1'b0, 1'b0, 32'h8000_0000, 32'd2);
    run_op(32, 1'b1, 1'b0, 32'd100, 32'd7);
    run_op(32, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(32, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32, 1'b1, 1'b0, 32'd5, 32'd0);

    kill_run(1'b0, 10);
    run_op(32, 1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_0123);
    kill_run(1'b0, 32);

    // annul together with start in IDLE drops the start (divide by zero would show at once)
    @(negedge clk);
    drive(32, 1'b1, 1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    drive(32, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    get(32, rdy, bsy, dz, res);
    check_eq("annul_start_ready", 64'(rdy), 64'd0);
    check_eq("annul_start_busy", 64'(bsy), 64'd0);

    kill_run(1'b1, 5);
    random_ops(32, 30);

    run_op(8, 1'b0, 1'b1, 32'h80, 32'h80);
    run_op(8, 1'b1, 1'b1, 32'hFF, 32'h03);
    run_op(8, 1'b1, 1'b0, 32'h37, 32'h00);
    random_ops(8, 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the EX stage, producing the {HI, LO} pair for MULT/MULTU/DIV/DIVU. It generalises the single-cycle signed/unsigned multiply path to any even operand width and adds iterative restoring division. Division-by-zero detection and annulment are included. EX starts an operation, stalls the pipeline while the unit reports busy, then writes HI/LO when the unit pulses ready.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; even, >= 4. Sets iteration count and result width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high (rst = 1'b1 is `RstEnable`).
- start_i  in  1  start request; sampled only in IDLE.
- annul_i  in  1  cancel the operation in flight (branch flush / exception).
- div_i  in  1  0 = multiply, 1 = divide; sampled with start_i.
- signed_i  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU); sampled with start_i.
- opdata1_i  in  WIDTH  multiplicand or dividend.
- opdata2_i  in  WIDTH  multiplier or divisor.
- result_o  out  2*WIDTH  mult: {hi, lo} product; div: {remainder, quotient}.
- ready_o  out  1  one-cycle pulse; result_o is valid.
- busy_o  out  1  operation in progress; EX stalls while high.
- divzero_o  out  1  high with ready_o when the divisor was zero.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 and annul_i=0: latch operands, div_i and signed_i.
  - If div_i=1 and opdata2_i=0: go to DONE with result_o=0 and divzero_o=1.
  - Otherwise go to RUN with cnt=0.
- Signed pre-processing: each negative operand is replaced by its two's complement magnitude. Record sign_q = sign1 ^ sign2 and sign_r = sign1.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first. 2*WIDTH accumulator; no overflow possible.
- RUN, divide: restoring, one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits. Trial subtract each cycle.
  - If the trial is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
- RUN lasts exactly WIDTH cycles; cnt wraps to DONE when cnt = WIDTH-1.
- Entering DONE, signed fix-up:
  - Product is negated if sign_q.
  - Quotient is negated if sign_q.
  - Remainder is negated if sign_r.
  - Most-negative / -1 yields quotient 2^(WIDTH-1) (bit pattern unchanged) and remainder 0. No trap.
- DONE: ready_o=1 for one cycle, then IDLE.
- result_o: registered; written only on entry to DONE; holds its value until the next DONE.
- busy_o: combinational, equals (state == RUN).
- divzero_o: high only in a DONE entered via the divide-by-zero path.
- annul_i:
  - In RUN or DONE: go to IDLE next cycle. No ready_o pulse after that edge; result_o unchanged.
  - In IDLE with start_i: annul wins; the start is dropped.
- start_i outside IDLE is ignored. Operand changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE, result_o=0, ready_o=0, busy_o=0, divzero_o=0, cnt=0.
- Reset mid-operation: back to IDLE next edge; no ready_o pulse.
- Normal operation, start accepted at edge T:
  - busy_o high cycles T+1 .. T+WIDTH.
  - ready_o high in cycle T+WIDTH+1, with result_o valid from that cycle.
  - Total latency is WIDTH+1 cycles (33 at WIDTH=32).
- Divide by zero: ready_o and divzero_o high in cycle T+1; busy_o never asserts.
- Back-to-back: start_i may be asserted in the DONE cycle, but it is ignored. The earliest next acceptance is the following IDLE cycle, so one idle cycle is the minimum between operations.
- annul_i and the last RUN cycle together: annul wins; no ready_o.
- ready_o is never high for two consecutive cycles.

## Test plan
- Unsigned multiply, WIDTH=32: 0xFFFFFFFF * 0xFFFFFFFF.
  - ready_o exactly 33 cycles after start.
  - result_o = 0xFFFFFFFE_00000001; busy_o high for 32 cycles.
- Signed multiply: -3 * 7 -> result_o = 0xFFFFFFFF_FFFFFFEB. Unsigned 0x80000000 * 2 -> 0x00000001_00000000.
- Divide:
  - Unsigned 100 / 7 -> {rem 2, quo 14}.
  - Signed -7 / 2 -> {rem 0xFFFFFFFF, quo 0xFFFFFFFD}.
  - Signed 0x80000000 / 0xFFFFFFFF -> {rem 0, quo 0x80000000}, divzero_o=0.
- Divide by zero: 5 / 0 -> ready_o and divzero_o at T+1, result_o=0, busy_o stays 0.
- Annul and reset mid-run:
  - Annul in RUN cycle 10: busy_o falls next cycle, no ready_o, result_o keeps its previous value.
  - A new start is accepted in the following IDLE and completes correctly.
  - rst at RUN cycle 5: all outputs return to reset values.
- Parameter check, WIDTH=8:
  - Signed 0x80 * 0x80 -> 0x4000; 0xFF / 0x03 signed -> {rem 0xFF, quo 0x00}.
  - ready_o at T+9; start during RUN/DONE ignored.
